multiexp_fp2_feeder: RTL and testbench
======================================

Name: multiexp_fp2_feeder

Overview:
- Upstream stage of the G2 multiexp core.
- Captures NUM_IN (scalar, Fp2 point) pairs from a load stream into local BRAM.
- Replays them as a looping stream KEY_BITS times, MSB-first. On pass k the scalar word is left-shifted by k, so the core's bit test at [KEY_BITS-1] sees scalar bit KEY_BITS-1-k.
- Output format is 7 FE-wide beats per pair: scalar, then point words 0..5.

Parameters:
- DAT_BITS, 381: width of one FE word (one beat).
- KEY_BITS, 256: scalar width and number of replay passes.
- MAX_IN, 1024: maximum pairs stored. Memory depth is 7*MAX_IN words.
- CTL_BITS, 16: ctl width, matching the core.

Ports:
- i_clk, in, 1: clock.
- i_rst, in, 1: reset, synchronous, active-high.
- i_num_in, in, $clog2(MAX_IN)+1: pair count, sampled on i_start.
- i_start, in, 1: 1-cycle pulse that begins LOAD. Honoured only in IDLE.
- i_load_if, if_axi_stream.sink, DAT_BITS: load beats. sop marks beat 0 (the scalar) of each pair.
- o_pnt_scl_if, if_axi_stream.source, DAT_BITS: replay stream to the multiexp core.
- o_busy, out, 1: high in any state other than IDLE.
- o_done, out, 1: 1-cycle pulse after the final beat of the final pass is accepted.
- o_err, out, 1: sticky error flag, cleared only by i_rst.

Behaviour:
- Reset values: o_pnt_scl_if.val/sop/eop/dat/ctl = 0; i_load_if.rdy = 0; o_busy = 0; o_done = 0; o_err = 0; state = IDLE; all counters = 0.
- State IDLE:
  - i_start with 1 <= i_num_in <= MAX_IN: latch num_in, go to LOAD.
  - i_start with i_num_in = 0 or i_num_in > MAX_IN: set o_err, remain in IDLE.
- State LOAD:
  - i_load_if.rdy = 1.
  - Each accepted beat is written to mem[pair*7 + beat]. beat wraps 6 -> 0, then pair increments.
  - Accepted beat with sop != (beat == 0): set o_err; the beat is still written.
  - After beat 6 of pair num_in-1: rdy drops the next cycle; go to PLAY with pass = 0, pair = 0, beat = 0.
- State PLAY:
  - Memory read latency is 1 cycle. A 2-entry output skid buffer absorbs it, so sustained throughput is 1 beat/cycle whenever o_pnt_scl_if.rdy is held high.
  - Read address advances only when the skid has space.
  - Beat 0 dat = (stored scalar << pass), truncated to DAT_BITS, with upper bits zero-filled at [DAT_BITS-1:KEY_BITS].
  - Beats 1..6: stored words, unmodified.
  - sop = (beat == 0); eop = (beat == 6); ctl = 0 (ctl[0] = 0 selects normal mode in the core).
  - Standard AXI stream rules: once val is asserted, dat/sop/eop/ctl stay stable until val && rdy.
  - Beat counter wraps 6 -> 0, then pair increments. pair wraps num_in-1 -> 0, then pass increments.
  - After the handshake of beat 6 of pair num_in-1 on pass KEY_BITS-1: go to DONE.
- State DONE: assert o_done for 1 cycle, go to IDLE.
- Simultaneous events:
  - i_start outside IDLE is ignored.
  - i_load_if.val outside LOAD is not accepted (rdy = 0).
- Reset mid-operation: returns to IDLE within 1 cycle and clears val and counters. Memory contents are undefined after reset and must be reloaded.
- Single pair (num_in = 1): each pass is 7 beats; total 7*KEY_BITS beats.
- Total output beats per job: 7*num_in*KEY_BITS, with no gaps inserted by this block.

Test Plan:
- KEY_BITS=4, num_in=2, scalars 4'b1010 and 4'b0011, point words 1..6 and 11..16, output rdy tied high. Required: 56 beats. Beat-0 bit[3] sequence per pass = (1,0), (0,0), (1,1), (0,1). Point words repeat unchanged every pass. o_done pulses once, 1 cycle after the last eop handshake.
- Same job with output rdy toggled by a random 50% pattern. Required: beat sequence identical to the rdy-high case; no dropped or duplicated beats; dat stable whenever val && !rdy.
- i_start with i_num_in=0, then a separate i_start with i_num_in=MAX_IN+1. Required: o_err=1 after each; state stays IDLE; o_busy=0; i_load_if.rdy stays 0.
- Load with sop asserted on beat 3 of pair 0. Required: o_err=1; the job still completes with 7*num_in*KEY_BITS beats.
- num_in=1, KEY_BITS=4, scalar=4'b1111. Required: 28 beats; every beat 0 has bit[3]=1; sop/eop alternate correctly.
- Assert i_rst during PLAY at pass 2. Required: val=0 and o_busy=0 on the next cycle. A subsequent i_start/load/replay completes normally with correct data.

Source files
------------

// File: rtl/multiexp_fp2_feeder.sv
// multiexp_fp2_feeder
//   Upstream feeder for the G2 multiexp core. It captures num_in
//   (scalar, Fp2 point) pairs, 7 FE beats each, into local memory. It then
//   replays the whole set KEY_BITS times. On pass k the scalar beat is the
//   stored scalar shifted left by k (kept to KEY_BITS bits), so the core's
//   test of bit [KEY_BITS-1] walks the scalar MSB-first.
//
// Ports
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_num_in, i_start   pair count, sampled on the i_start pulse in IDLE
//   i_load_*            load stream sink (val/rdy/sop/dat); sop marks beat 0
//   o_pnt_scl_*         replay stream source (val/rdy/sop/eop/dat/ctl)
//   o_busy              high whenever the block is not IDLE
//   o_done              1-cycle pulse after the final beat is accepted
//   o_err               sticky: bad pair count or misplaced load sop
module multiexp_fp2_feeder #(
  parameter int DAT_BITS = 381,
  parameter int KEY_BITS = 256,
  parameter int MAX_IN   = 1024,
  parameter int CTL_BITS = 16
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [$clog2(MAX_IN):0]   i_num_in,
  input  logic                      i_start,
  input  logic                      i_load_val,
  output logic                      i_load_rdy,
  input  logic                      i_load_sop,
  input  logic [DAT_BITS-1:0]       i_load_dat,
  output logic                      o_pnt_scl_val,
  input  logic                      o_pnt_scl_rdy,
  output logic                      o_pnt_scl_sop,
  output logic                      o_pnt_scl_eop,
  output logic [DAT_BITS-1:0]       o_pnt_scl_dat,
  output logic [CTL_BITS-1:0]       o_pnt_scl_ctl,
  output logic                      o_busy,
  output logic                      o_done,
  output logic                      o_err
);

  localparam int NUM_W  = $clog2(MAX_IN) + 1;
  localparam int DEPTH  = 7 * MAX_IN;
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int PASS_W = (KEY_BITS > 1) ? $clog2(KEY_BITS) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, PLAY, DONE} state_t;

  // One replay beat as it sits in the output skid buffer.
  typedef struct packed {
    logic                sop;
    logic                eop;
    logic                last;   // final beat of the final pass
    logic [DAT_BITS-1:0] dat;
  } beat_t;

  state_t state, state_n;

  logic [NUM_W-1:0]    num_q;
  logic [ADDR_W-1:0]   wr_addr, rd_addr;
  logic [2:0]          ld_beat, rd_beat;
  logic [NUM_W-1:0]    ld_pair, rd_pair;
  logic [PASS_W-1:0]   rd_pass;
  logic                rd_all;

  logic [DAT_BITS-1:0] mem [DEPTH];
  logic [DAT_BITS-1:0] rd_word;

  // Sideband for the read in flight (memory latency is one cycle).
  logic                rd_vld;
  logic                md_sop, md_eop, md_last;
  logic [PASS_W-1:0]   md_pass;

  beat_t               q [2];
  logic [1:0]          cnt;

  logic                num_ok, ld_acc, pop, issue;
  logic [2:0]          occ_n;
  logic [KEY_BITS-1:0] scl_shf;
  beat_t               ret_beat;

  assign num_ok = (i_num_in != '0) && (i_num_in <= NUM_W'(MAX_IN));
  assign ld_acc = (state == LOAD) && i_load_val;
  assign pop    = o_pnt_scl_val && o_pnt_scl_rdy;

  // Only issue a read when the skid is guaranteed room for it after this
  // cycle's pop plus whatever read is already returning.
  assign occ_n = 3'(cnt) + 3'(rd_vld) - 3'(pop);
  assign issue = (state == PLAY) && !rd_all && (occ_n < 3'd2);

  assign scl_shf           = rd_word[KEY_BITS-1:0] << md_pass;
  assign ret_beat.sop      = md_sop;
  assign ret_beat.eop      = md_eop;
  assign ret_beat.last     = md_last;
  assign ret_beat.dat      = md_sop ? DAT_BITS'(scl_shf) : rd_word;

  assign i_load_rdy    = (state == LOAD);
  assign o_busy        = (state != IDLE);
  assign o_done        = (state == DONE);
  assign o_pnt_scl_val = (cnt != 2'd0);
  assign o_pnt_scl_sop = q[0].sop;
  assign o_pnt_scl_eop = q[0].eop;
  assign o_pnt_scl_dat = q[0].dat;
  assign o_pnt_scl_ctl = '0;

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (i_start && num_ok) state_n = LOAD;
      LOAD: if (ld_acc && ld_beat == 3'd6 && ld_pair == num_q - NUM_W'(1))
              state_n = PLAY;
      PLAY: if (pop && q[0].last) state_n = DONE;
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Storage: no reset, contents are reloaded for every job.
  always_ff @(posedge i_clk) begin
    if (ld_acc) mem[wr_addr] <= i_load_dat;
    if (issue)  rd_word      <= mem[rd_addr];
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      num_q   <= '0;
      o_err   <= 1'b0;
      wr_addr <= '0;
      ld_beat <= '0;
      ld_pair <= '0;
      rd_addr <= '0;
      rd_beat <= '0;
      rd_pair <= '0;
      rd_pass <= '0;
      rd_all  <= 1'b0;
      rd_vld  <= 1'b0;
      md_sop  <= 1'b0;
      md_eop  <= 1'b0;
      md_last <= 1'b0;
      md_pass <= '0;
      cnt     <= '0;
      q[0]    <= '0;
      q[1]    <= '0;
    end else begin
      if (state == IDLE) begin
        wr_addr <= '0;
        ld_beat <= '0;
        ld_pair <= '0;
        rd_addr <= '0;
        rd_beat <= '0;
        rd_pair <= '0;
        rd_pass <= '0;
        rd_all  <= 1'b0;
        if (i_start) begin
          if (num_ok) num_q <= i_num_in;
          else        o_err <= 1'b1;
        end
      end

      if (ld_acc) begin
        wr_addr <= wr_addr + ADDR_W'(1);
        if (i_load_sop != (ld_beat == 3'd0)) o_err <= 1'b1;
        if (ld_beat == 3'd6) begin
          ld_beat <= '0;
          ld_pair <= ld_pair + NUM_W'(1);
        end else begin
          ld_beat <= ld_beat + 3'd1;
        end
      end

      rd_vld <= issue;
      if (issue) begin
        md_sop  <= (rd_beat == 3'd0);
        md_eop  <= (rd_beat == 3'd6);
        md_pass <= rd_pass;
        md_last <= (rd_beat == 3'd6) && (rd_pair == num_q - NUM_W'(1)) &&
                   (rd_pass == PASS_W'(KEY_BITS - 1));
        rd_addr <= rd_addr + ADDR_W'(1);
        if (rd_beat == 3'd6) begin
          rd_beat <= '0;
          if (rd_pair == num_q - NUM_W'(1)) begin
            // Pairs are stored back to back, so a new pass restarts at 0.
            rd_pair <= '0;
            rd_addr <= '0;
            if (rd_pass == PASS_W'(KEY_BITS - 1)) rd_all  <= 1'b1;
            else                                  rd_pass <= rd_pass + PASS_W'(1);
          end else begin
            rd_pair <= rd_pair + NUM_W'(1);
          end
        end else begin
          rd_beat <= rd_beat + 3'd1;
        end
      end

      // Two-entry skid; head is q[0].
      case ({rd_vld, pop})
        2'b10: begin
          q[cnt[0]] <= ret_beat;
          cnt       <= cnt + 2'd1;
        end
        2'b01: begin
          q[0] <= q[1];
          cnt  <= cnt - 2'd1;
        end
        2'b11: begin
          if (cnt == 2'd1) begin
            q[0] <= ret_beat;
          end else begin
            q[0] <= q[1];
            q[1] <= ret_beat;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multiexp_fp2_feeder.sv
module tb_multiexp_fp2_feeder;
  localparam int DW = 32;
  localparam int KB = 4;
  localparam int MI = 4;
  localparam int CB = 16;
  localparam int NW = $clog2(MI) + 1;

  logic          i_clk = 1'b0;
  logic          i_rst = 1'b1;
  logic [NW-1:0] i_num_in = '0;
  logic          i_start = 1'b0;
  logic          i_load_val = 1'b0;
  logic          i_load_rdy;
  logic          i_load_sop = 1'b0;
  logic [DW-1:0] i_load_dat = '0;
  logic          o_val;
  logic          o_rdy = 1'b0;
  logic          o_sop, o_eop;
  logic [DW-1:0] o_dat;
  logic [CB-1:0] o_ctl;
  logic          o_busy, o_done, o_err;

  always #5 i_clk = ~i_clk;

  multiexp_fp2_feeder #(.DAT_BITS(DW), .KEY_BITS(KB), .MAX_IN(MI), .CTL_BITS(CB)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_num_in(i_num_in), .i_start(i_start),
    .i_load_val(i_load_val), .i_load_rdy(i_load_rdy), .i_load_sop(i_load_sop),
    .i_load_dat(i_load_dat),
    .o_pnt_scl_val(o_val), .o_pnt_scl_rdy(o_rdy), .o_pnt_scl_sop(o_sop),
    .o_pnt_scl_eop(o_eop), .o_pnt_scl_dat(o_dat), .o_pnt_scl_ctl(o_ctl),
    .o_busy(o_busy), .o_done(o_done), .o_err(o_err)
  );

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [DW-1:0] dat;
    logic          sop;
    logic          eop;
  } xb_t;

  logic [DW-1:0] pairs [MI][7];
  xb_t           expq[$];
  int            b3q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    repeat (2) @(posedge i_clk);
    #1 i_rst = 1'b0;
  endtask

  task automatic fill_random(input int n);
    for (int j = 0; j < n; j++)
      for (int b = 0; b < 7; b++) pairs[j][b] = $urandom;
  endtask

  // Replay order: pass, then pair, then beat. Scalar beat keeps only the
  // low KEY_BITS bits of (scalar * 2^pass).
  task automatic build_model(input int n);
    logic [DW-1:0] m;
    xb_t e;
    m = DW'(1) << KB;
    expq.delete();
    for (int p = 0; p < KB; p++)
      for (int j = 0; j < n; j++)
        for (int b = 0; b < 7; b++) begin
          e.dat = (b == 0) ? (((pairs[j][0] % m) * (DW'(1) << p)) % m) : pairs[j][b];
          e.sop = (b == 0);
          e.eop = (b == 6);
          expq.push_back(e);
        end
  endtask

  task automatic load_job(input int n, input bit bad_sop);
    int w;
    @(posedge i_clk); #1;
    i_num_in = NW'(n);
    i_start  = 1'b1;
    @(posedge i_clk); #1;
    i_start  = 1'b0;
    for (int j = 0; j < n; j++)
      for (int b = 0; b < 7; b++) begin
        if ($urandom_range(0, 3) == 0) begin
          i_load_val = 1'b0;
          @(posedge i_clk); #1;
        end
        i_load_val = 1'b1;
        i_load_sop = (b == 0) || (bad_sop && j == 0 && b == 3);
        i_load_dat = pairs[j][b];
        w = 0;
        @(negedge i_clk);
        while (!i_load_rdy && w < 20) begin
          @(negedge i_clk);
          w++;
        end
        chk("load_rdy", 64'(i_load_rdy), 64'd1);
        @(posedge i_clk); #1;
      end
    i_load_val = 1'b0;
    i_load_sop = 1'b0;
    @(negedge i_clk);
    chk("load_rdy_drop", 64'(i_load_rdy), 64'd0);
    chk("busy_play", 64'(o_busy), 64'd1);
  endtask

  task automatic play_job(input int n, input bit rnd, input int abort_after, input bit chk_gap);
    int got, cyc, done_cnt, last_hs, first_hs, total;
    bit prev_stall;
    logic [DW-1:0] pd;
    logic ps, pe;
    xb_t e;
    got = 0; cyc = 0; done_cnt = 0; last_hs = -10; first_hs = -1;
    total = expq.size();
    prev_stall = 1'b0; pd = '0; ps = 1'b0; pe = 1'b0;
    b3q.delete();
    while (cyc < 4000) begin
      @(posedge i_clk); #1;
      o_rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge i_clk);
      cyc++;
      if (o_done) begin
        done_cnt++;
        chk("done_timing", 64'(cyc), 64'(last_hs + 1));
        break;
      end
      if (prev_stall) begin
        chk("stall_val", 64'(o_val), 64'd1);
        chk("stall_dat", 64'(o_dat), 64'(pd));
        chk("stall_sop", 64'(o_sop), 64'(ps));
        chk("stall_eop", 64'(o_eop), 64'(pe));
      end
      if (o_val && o_rdy) begin
        if (expq.size() == 0) begin
          chk("extra_beat", 64'(got + 1), 64'(total));
          break;
        end
        e = expq.pop_front();
        chk("beat_dat", 64'(o_dat), 64'(e.dat));
        chk("beat_sop", 64'(o_sop), 64'(e.sop));
        chk("beat_eop", 64'(o_eop), 64'(e.eop));
        chk("beat_ctl", 64'(o_ctl), 64'd0);
        if (e.sop) b3q.push_back(int'(o_dat[KB-1]));
        got++;
        if (first_hs < 0) first_hs = cyc;
        last_hs = cyc;
        if (got == abort_after) begin
          @(posedge i_clk); #1;
          i_rst = 1'b1;
          @(posedge i_clk);
          @(negedge i_clk);
          chk("rst_val", 64'(o_val), 64'd0);
          chk("rst_busy", 64'(o_busy), 64'd0);
          chk("rst_load_rdy", 64'(i_load_rdy), 64'd0);
          @(posedge i_clk); #1;
          i_rst = 1'b0;
          o_rdy = 1'b0;
          return;
        end
      end
      prev_stall = o_val && !o_rdy;
      pd = o_dat; ps = o_sop; pe = o_eop;
    end
    chk("beats", 64'(got), 64'(total));
    chk("done_pulses", 64'(done_cnt), 64'd1);
    if (chk_gap) chk("gapless", 64'(last_hs - first_hs + 1), 64'(total));
    @(posedge i_clk); #1;
    o_rdy = 1'b0;
    @(negedge i_clk);
    chk("done_drop", 64'(o_done), 64'd0);
    chk("idle_busy", 64'(o_busy), 64'd0);
  endtask

  int exp_b3 [8] = '{1, 0, 0, 0, 1, 1, 0, 1};

  initial begin
    do_reset();
    @(negedge i_clk);
    chk("rst_val", 64'(o_val), 64'd0);
    chk("rst_sop", 64'(o_sop), 64'd0);
    chk("rst_eop", 64'(o_eop), 64'd0);
    chk("rst_dat", 64'(o_dat), 64'd0);
    chk("rst_ctl", 64'(o_ctl), 64'd0);
    chk("rst_load_rdy", 64'(i_load_rdy), 64'd0);
    chk("rst_busy", 64'(o_busy), 64'd0);
    chk("rst_done", 64'(o_done), 64'd0);
    chk("rst_err", 64'(o_err), 64'd0);

    // Illegal pair counts: 0, then MAX_IN+1.
    for (int t = 0; t < 2; t++) begin
      @(posedge i_clk); #1;
      i_num_in = (t == 0) ? NW'(0) : NW'(MI + 1);
      i_start  = 1'b1;
      @(posedge i_clk); #1;
      i_start  = 1'b0;
      @(negedge i_clk);
      chk("bad_num_err", 64'(o_err), 64'd1);
      chk("bad_num_busy", 64'(o_busy), 64'd0);
      chk("bad_num_load_rdy", 64'(i_load_rdy), 64'd0);
      @(negedge i_clk);
      chk("bad_num_stay_idle", 64'(o_busy), 64'd0);
      do_reset();
      @(negedge i_clk);
      chk("err_cleared", 64'(o_err), 64'd0);
    end

    // Directed job, output rdy high then random.
    for (int t = 0; t < 2; t++) begin
      pairs[0][0] = 32'hA;
      pairs[1][0] = 32'h3;
      for (int b = 1; b < 7; b++) begin
        pairs[0][b] = DW'(b);
        pairs[1][b] = DW'(b + 10);
      end
      build_model(2);
      load_job(2, 1'b0);
      play_job(2, t[0], -1, (t == 0));
      chk("b3_count", 64'(b3q.size()), 64'd8);
      for (int i = 0; i < 8 && i < b3q.size(); i++)
        chk("b3_seq", 64'(b3q[i]), 64'(exp_b3[i]));
      chk("no_err", 64'(o_err), 64'd0);
    end

    // Single pair, all-ones scalar (upper bits random, must be dropped).
    fill_random(1);
    pairs[0][0] = {$urandom} & ~32'hF | 32'hF;
    build_model(1);
    load_job(1, 1'b0);
    play_job(1, 1'b0, -1, 1'b1);
    chk("single_b3_count", 64'(b3q.size()), 64'(KB));
    for (int i = 0; i < b3q.size(); i++) chk("single_b3", 64'(b3q[i]), 64'd1);

    // Full depth, random data and back-pressure.
    fill_random(MI);
    build_model(MI);
    load_job(MI, 1'b0);
    play_job(MI, 1'b1, -1, 1'b0);
    chk("full_no_err", 64'(o_err), 64'd0);

    // Misplaced sop on beat 3 of pair 0.
    fill_random(2);
    build_model(2);
    load_job(2, 1'b1);
    chk("sop_err", 64'(o_err), 64'd1);
    play_job(2, 1'b1, -1, 1'b0);
    chk("sop_err_sticky", 64'(o_err), 64'd1);
    do_reset();

    // Reset during pass 2, then a clean job.
    fill_random(2);
    build_model(2);
    load_job(2, 1'b0);
    play_job(2, 1'b1, 2 * 7 * 2 + 3, 1'b0);
    fill_random(3);
    build_model(3);
    load_job(3, 1'b0);
    play_job(3, 1'b1, -1, 1'b0);
    chk("after_rst_no_err", 64'(o_err), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
